// File: rtl/mem_bus_arbiter.sv
// Serialises the core's instruction-read, data-read and data-write handshakes onto one single-port RAM.
// Latency: write_finish 2 cycles and read_valid RD_LAT+1 cycles after grant; losing requests wait, in priority order.
module mem_bus_arbiter #(
    parameter int ADR_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_read_req,
    input  logic             i_read_w,
    input  logic             i_read_hw,
    input  logic [31:0]      i_read_adr,
    input  logic             d_read_req,
    input  logic             d_read_w,
    input  logic             d_read_hw,
    input  logic [31:0]      d_read_adr,
    input  logic             d_write_req,
    input  logic             d_write_w,
    input  logic             d_write_hw,
    input  logic [31:0]      d_write_adr,
    input  logic [31:0]      d_write_data,
    output logic             read_valid,
    output logic [31:0]      read_data,
    output logic             write_finish,
    output logic             mem_en,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [ADR_W-3:0] mem_adr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             misalign
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_RDW,
        S_RESP,
        S_HOLD
    } state_t;

    localparam logic [1:0] SZ_B     = 2'd0;
    localparam logic [1:0] SZ_H     = 2'd1;
    localparam logic [1:0] SZ_W     = 2'd2;
    localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [1:0]        sz_q, sz_d;
    logic [1:0]        lo_q, lo_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADR_W-3:0]  mem_adr_q, mem_adr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       read_data_q, read_data_d;

    logic              g_vld, g_wr, g_w, g_hw;
    logic [31:0]       g_adr;
    logic [1:0]        g_sz;
    logic [1:0]        g_lo;
    logic [3:0]        g_be;
    logic [31:0]       g_wdata;
    logic              g_mis;
    logic [31:0]       rsel;
    logic              unused_adr_hi;

    // Fixed priority: write > data read > instruction read.
    always_comb begin
        g_vld = 1'b1;
        g_wr  = 1'b0;
        g_w   = i_read_w;
        g_hw  = i_read_hw;
        g_adr = i_read_adr;
        if (d_write_req) begin
            g_wr  = 1'b1;
            g_w   = d_write_w;
            g_hw  = d_write_hw;
            g_adr = d_write_adr;
        end else if (d_read_req) begin
            g_w   = d_read_w;
            g_hw  = d_read_hw;
            g_adr = d_read_adr;
        end else if (!i_read_req) begin
            g_vld = 1'b0;
        end
    end

    assign g_sz          = g_w ? SZ_W : (g_hw ? SZ_H : SZ_B);
    assign g_lo          = g_adr[1:0];
    assign g_mis         = ((g_sz == SZ_H) && g_lo[0]) || ((g_sz == SZ_W) && (g_lo != 2'd0));
    assign unused_adr_hi = ^g_adr[31:ADR_W];

    // Lane enables ignore the sub-size address bits, which aligns misaligned accesses down.
    always_comb begin
        g_be    = 4'b0001 << g_lo;
        g_wdata = {4{d_write_data[7:0]}};
        case (g_sz)
            SZ_W: begin
                g_be    = 4'b1111;
                g_wdata = d_write_data;
            end
            SZ_H: begin
                g_be    = g_lo[1] ? 4'b1100 : 4'b0011;
                g_wdata = {2{d_write_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rsel = {24'h0, mem_rdata[{lo_q, 3'b000} +: 8]};
        case (sz_q)
            SZ_W:    rsel = mem_rdata;
            SZ_H:    rsel = {16'h0, lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        sz_d        = sz_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = 4'b0000;
        mem_adr_d   = '0;
        mem_wdata_d = 32'h0;
        misalign_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (g_vld) begin
                    state_d     = S_ACC;
                    wr_d        = g_wr;
                    sz_d        = g_sz;
                    lo_d        = g_lo;
                    mem_en_d    = 1'b1;
                    mem_we_d    = g_wr;
                    mem_be_d    = g_be;
                    mem_adr_d   = g_adr[ADR_W-1:2];
                    mem_wdata_d = g_wr ? g_wdata : 32'h0;
                    misalign_d  = g_mis;
                end
            end
            S_ACC: begin
                if (wr_q || (RD_LAT == 1)) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_RDW;
                    cnt_d   = CNT_INIT;
                end
            end
            S_RDW: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP:  state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // RAM data is valid in RESP itself, so it is forwarded there and held afterwards.
    assign read_valid   = (state_q == S_RESP) && !wr_q;
    assign write_finish = (state_q == S_RESP) && wr_q;
    assign read_data_d  = read_valid ? rsel : read_data_q;
    assign read_data    = read_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            sz_q        <= SZ_B;
            lo_q        <= 2'd0;
            cnt_q       <= 2'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_adr_q   <= '0;
            mem_wdata_q <= 32'h0;
            misalign_q  <= 1'b0;
            read_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            sz_q        <= sz_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            misalign_q  <= misalign_d;
            read_data_q <= read_data_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances with RD_LAT 1, 2, 3, each with its own RAM model.
module tb_mem_bus_arbiter;
    localparam int ADR_W = 16;
    localparam int AW    = ADR_W - 2;

    typedef struct packed {
        logic        ireq, iw, ihw;
        logic [31:0] iadr;
        logic        dreq, dw, dhw;
        logic [31:0] dadr;
        logic        wreq, ww, whw;
        logic [31:0] wadr, wdat;
    } req_t;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        int          kind;   // 0 instr read, 1 data read, 2 data write
        logic        w, hw;
        logic [31:0] adr, wdat;
        logic [3:0]  be;
        logic [31:0] ewd, erd;
        logic        emis;
    } vec_t;

    logic          clk = 1'b0;
    int            cyc = 0;
    req_t          rq   [3];
    logic          rst  [3];
    logic          rv   [3];
    logic          wf   [3];
    logic          men  [3];
    logic          mwe  [3];
    logic          mis  [3];
    logic [31:0]   rd   [3];
    logic [31:0]   mwd  [3];
    logic [31:0]   mrd  [3];
    logic [3:0]    mbe  [3];
    logic [AW-1:0] madr [3];
    logic [31:0]   last_rd [3];
    exp_t          sb   [3][$];
    int            nvec = 0;
    int            nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] ram [0:(1<<AW)-1];
        logic [31:0] p0, p1, p2;

        mem_bus_arbiter #(.ADR_W(ADR_W), .RD_LAT(g + 1)) u_dut (
            .clk(clk), .rst(rst[g]),
            .i_read_req(rq[g].ireq), .i_read_w(rq[g].iw), .i_read_hw(rq[g].ihw), .i_read_adr(rq[g].iadr),
            .d_read_req(rq[g].dreq), .d_read_w(rq[g].dw), .d_read_hw(rq[g].dhw), .d_read_adr(rq[g].dadr),
            .d_write_req(rq[g].wreq), .d_write_w(rq[g].ww), .d_write_hw(rq[g].whw),
            .d_write_adr(rq[g].wadr), .d_write_data(rq[g].wdat),
            .read_valid(rv[g]), .read_data(rd[g]), .write_finish(wf[g]),
            .mem_en(men[g]), .mem_we(mwe[g]), .mem_be(mbe[g]), .mem_adr(madr[g]),
            .mem_wdata(mwd[g]), .mem_rdata(mrd[g]), .misalign(mis[g]));

        initial begin
            for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
            p0 = 32'h0;
            p1 = 32'h0;
            p2 = 32'h0;
        end

        // Registered read, then RD_LAT-1 extra pipeline stages.
        always @(posedge clk) begin
            if (men[g]) begin
                if (mwe[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (mbe[g][b]) ram[madr[g]][8*b +: 8] <= mwd[g][8*b +: 8];
                end
                p0 <= ram[madr[g]];
            end
            p1 <= p0;
            p2 <= p1;
        end

        assign mrd[g] = (g == 0) ? p0 : ((g == 1) ? p1 : p2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mkv(input int kind, input logic w, input logic hw, input logic [31:0] adr,
                                 input logic [31:0] wdat, input logic [3:0] be, input logic [31:0] ewd,
                                 input logic [31:0] erd, input logic emis);
        vec_t v;
        v.kind = kind; v.w = w; v.hw = hw; v.adr = adr; v.wdat = wdat;
        v.be = be; v.ewd = ewd; v.erd = erd; v.emis = emis;
        return v;
    endfunction

    task automatic start(input int k, input int kind, input logic w, input logic hw,
                         input logic [31:0] adr, input logic [31:0] dat);
        case (kind)
            0: begin rq[k].ireq = 1'b1; rq[k].iw = w; rq[k].ihw = hw; rq[k].iadr = adr; end
            1: begin rq[k].dreq = 1'b1; rq[k].dw = w; rq[k].dhw = hw; rq[k].dadr = adr; end
            default: begin
                rq[k].wreq = 1'b1; rq[k].ww = w; rq[k].whw = hw; rq[k].wadr = adr; rq[k].wdat = dat;
            end
        endcase
    endtask

    task automatic stop(input int k, input int kind);
        case (kind)
            0:       rq[k].ireq = 1'b0;
            1:       rq[k].dreq = 1'b0;
            default: rq[k].wreq = 1'b0;
        endcase
    endtask

    task automatic push(input int k, input logic wr, input logic [31:0] data, input int due);
        exp_t e;
        e.wr = wr; e.data = data; e.due = due;
        sb[k].push_back(e);
    endtask

    task automatic wait_resp(input int k, input int kind, input string name);
        int n = 0;
        @(negedge clk);
        while (!(rv[k] || wf[k]) && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (!(rv[k] || wf[k])) begin
            nvec++;
            nfail++;
            $display("FAIL %s_timeout: got no response, required one within 12 cycles", name);
        end
        stop(k, kind);
    endtask

    task automatic chk_quiet(input int k, input string p);
        chk({p, "_read_valid"}, 32'(rv[k]), 32'h0);
        chk({p, "_write_finish"}, 32'(wf[k]), 32'h0);
        chk({p, "_mem_en"}, 32'(men[k]), 32'h0);
        chk({p, "_mem_we"}, 32'(mwe[k]), 32'h0);
        chk({p, "_mem_be"}, 32'(mbe[k]), 32'h0);
        chk({p, "_mem_adr"}, 32'(madr[k]), 32'h0);
        chk({p, "_mem_wdata"}, mwd[k], 32'h0);
        chk({p, "_read_data"}, rd[k], 32'h0);
        chk({p, "_misalign"}, 32'(mis[k]), 32'h0);
    endtask

    // Called at a negedge while the DUT is IDLE; returns at the next IDLE negedge.
    task automatic run_vec(input int k, input int lat, input vec_t v, input string name);
        logic wr;
        wr = (v.kind == 2);
        start(k, v.kind, v.w, v.hw, v.adr, v.wdat);
        push(k, wr, v.erd, cyc + (wr ? 2 : 1 + lat));
        @(negedge clk);
        chk({name, "_en"}, 32'(men[k]), 32'h1);
        chk({name, "_we"}, 32'(mwe[k]), 32'(wr));
        chk({name, "_be"}, 32'(mbe[k]), 32'(v.be));
        chk({name, "_adr"}, 32'(madr[k]), 32'(v.adr[ADR_W-1:2]));
        chk({name, "_mis"}, 32'(mis[k]), 32'(v.emis));
        if (wr) chk({name, "_wdata"}, mwd[k], v.ewd);
        wait_resp(k, v.kind, name);
        if (!wr) last_rd[k] = v.erd;
        @(negedge clk);
        chk({name, "_hold_en"}, 32'(men[k]), 32'h0);
        chk({name, "_hold_rdata"}, rd[k], last_rd[k]);
        @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rv[k] || wf[k]) begin
                if (sb[k].size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL spurious_resp inst%0d: got a response at cycle %0d, required none", k, cyc);
                end else begin
                    e = sb[k].pop_front();
                    chk($sformatf("i%0d_resp_is_write", k), 32'(wf[k]), 32'(e.wr));
                    chk($sformatf("i%0d_resp_cycle", k), cyc, e.due);
                    if (!e.wr) chk($sformatf("i%0d_read_data", k), rd[k], e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [16];
        int   n, got, c;
        for (int k = 0; k < 3; k++) begin
            rq[k] = '0;
            rst[k] = 1'b1;
            last_rd[k] = 32'h0;
        end
        tbl[0]  = mkv(2, 1, 0, 32'h0000_0104, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        tbl[1]  = mkv(0, 1, 0, 32'h0000_0104, 32'h0,       4'hF, 32'h0, 32'hDEADBEEF, 0);
        tbl[2]  = mkv(2, 0, 0, 32'h0000_0203, 32'h000000A5, 4'h8, 32'hA5A5A5A5, 32'h0, 0);
        tbl[3]  = mkv(1, 1, 0, 32'h0000_0200, 32'h0,       4'hF, 32'h0, 32'hA5000000, 0);
        tbl[4]  = mkv(2, 1, 0, 32'h0000_0300, 32'h1234ABCD, 4'hF, 32'h1234ABCD, 32'h0, 0);
        tbl[5]  = mkv(1, 0, 1, 32'h0000_0302, 32'h0,       4'hC, 32'h0, 32'h00001234, 0);
        tbl[6]  = mkv(1, 0, 1, 32'h0000_0301, 32'h0,       4'h3, 32'h0, 32'h0000ABCD, 1);
        tbl[7]  = mkv(1, 0, 0, 32'h0000_0301, 32'h0,       4'h2, 32'h0, 32'h000000AB, 0);
        tbl[8]  = mkv(2, 0, 1, 32'h0000_0106, 32'hFFFF5A3C, 4'hC, 32'h5A3C5A3C, 32'h0, 0);
        tbl[9]  = mkv(0, 0, 0, 32'h0000_0107, 32'h0,       4'h8, 32'h0, 32'h0000005A, 0);
        tbl[10] = mkv(1, 1, 0, 32'h0000_0106, 32'h0,       4'hF, 32'h0, 32'h5A3CBEEF, 1);
        tbl[11] = mkv(2, 0, 1, 32'h0000_0105, 32'h00007766, 4'h3, 32'h77667766, 32'h0, 1);
        tbl[12] = mkv(0, 0, 1, 32'h0000_0104, 32'h0,       4'h3, 32'h0, 32'h00007766, 0);
        tbl[13] = mkv(2, 1, 0, 32'h0000_020E, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 32'h0, 1);
        tbl[14] = mkv(1, 1, 0, 32'h0000_020C, 32'h0,       4'hF, 32'h0, 32'hCAFEF00D, 0);
        tbl[15] = mkv(0, 1, 0, 32'hFFFF_020C, 32'h0,       4'hF, 32'h0, 32'hCAFEF00D, 0);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_quiet(k, $sformatf("reset_i%0d", k));
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_vec(0, 1, tbl[i], $sformatf("v%0d", i));

        // Three simultaneous requesters: write, then data read, then instruction read.
        c = cyc;
        start(0, 2, 1, 0, 32'h400, 32'h11223344);
        start(0, 1, 1, 0, 32'h400, 32'h0);
        start(0, 0, 1, 0, 32'h104, 32'h0);
        push(0, 1'b1, 32'h0, c + 2);
        push(0, 1'b0, 32'h11223344, c + 6);
        push(0, 1'b0, 32'h5A3C7766, c + 10);
        got = 0;
        n = 0;
        while (got < 3 && n < 20) begin
            @(negedge clk);
            n++;
            if (rv[0] || wf[0]) begin
                stop(0, 2 - got);
                got++;
            end
        end
        chk("prio_resp_count", got, 3);
        repeat (2) @(negedge clk);
        last_rd[0] = 32'h5A3C7766;

        // Request withdrawn right after grant still completes.
        c = cyc;
        start(0, 1, 0, 0, 32'h402, 32'h0);
        push(0, 1'b0, 32'h00000022, c + 2);
        @(negedge clk);
        stop(0, 1);
        n = 0;
        while (!rv[0] && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk("drop_resp_seen", 32'(rv[0]), 32'h1);
        repeat (2) @(negedge clk);

        // RD_LAT=3: reset in the middle of the read-wait phase.
        run_vec(2, 3, mkv(2, 1, 0, 32'h10, 32'h55AA55AA, 4'hF, 32'h55AA55AA, 32'h0, 0), "l3_wr");
        start(2, 1, 1, 0, 32'h10, 32'h0);
        @(negedge clk);
        chk("l3_acc_en", 32'(men[2]), 32'h1);
        @(negedge clk);
        rst[2] = 1'b1;
        stop(2, 1);
        @(negedge clk);
        chk_quiet(2, "l3_after_rst");
        rst[2] = 1'b0;
        last_rd[2] = 32'h0;
        got = 0;
        repeat (6) begin
            @(negedge clk);
            if (rv[2] || wf[2]) got++;
        end
        chk("l3_no_resp_after_rst", got, 0);
        run_vec(2, 3, mkv(1, 1, 0, 32'h10, 32'h0, 4'hF, 32'h0, 32'h55AA55AA, 0), "l3_rd");

        // RD_LAT=2: back-to-back instruction reads with the request held high.
        run_vec(1, 2, mkv(2, 1, 0, 32'h8, 32'h0BADCAFE, 4'hF, 32'h0BADCAFE, 32'h0, 0), "l2_wr0");
        run_vec(1, 2, mkv(2, 1, 0, 32'hC, 32'h600DF00D, 4'hF, 32'h600DF00D, 32'h0, 0), "l2_wr1");
        c = cyc;
        start(1, 0, 1, 0, 32'h8, 32'h0);
        push(1, 1'b0, 32'h0BADCAFE, c + 3);
        n = 0;
        @(negedge clk);
        while (!rv[1] && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_seen", 32'(rv[1]), 32'h1);
        c = cyc;
        rq[1].iadr = 32'hC;
        push(1, 1'b0, 32'h600DF00D, c + 5);
        @(negedge clk);
        chk("b2b_resp_plus1_en", 32'(men[1]), 32'h0);
        @(negedge clk);
        chk("b2b_resp_plus2_en", 32'(men[1]), 32'h0);
        @(negedge clk);
        chk("b2b_resp_plus3_en", 32'(men[1]), 32'h1);
        chk("b2b_resp_plus3_adr", 32'(madr[1]), 32'h3);
        wait_resp(1, 0, "b2b_second");
        repeat (3) @(negedge clk);

        for (int k = 0; k < 3; k++) chk($sformatf("i%0d_outstanding", k), sb[k].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
